// File: rtl/cr_prefix_ob_buf_pkg.sv
// Shared types and constants for the prefix engine outbound buffer.
// Stream beat/ready structs, FSM states and stat bit positions.
package cr_prefix_ob_buf_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W / 8;
  localparam int USER_W = 4;

  typedef struct packed {
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } prefix_ob_buf_state_e;

  localparam int PREFIX_OB_BUF_STATS_WIDTH = 4;
  localparam int STAT_FRAME_DONE = 0;
  localparam int STAT_IB_STALL   = 1;
  localparam int STAT_OB_STALL   = 2;
  localparam int STAT_OVERSIZE   = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cr_prefix_ob_buf_fifo.sv
// Register FIFO of stream beats with separate occupancy counter.
// Storage is not reset; only pointers and count are.
module cr_prefix_ob_buf_fifo
  import cr_prefix_ob_buf_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  axi4s_dp_bus_t din,
  output axi4s_dp_bus_t dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  axi4s_dp_bus_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cr_prefix_ob_buf.sv
// Elastic outbound buffer for the prefix engine with frame monitor,
// occupancy/high-water reporting and registered stat event pulses.
module cr_prefix_ob_buf
  import cr_prefix_ob_buf_pkg::*;
#(
  parameter  int          DEPTH           = 8,
  parameter  logic [15:0] MAX_FRAME_BEATS = 16'hFFFF,
  localparam int          CW              = $clog2(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  axi4s_dp_bus_t                        ib_in,
  output axi4s_dp_rdy_t                        ib_out,
  input  axi4s_dp_rdy_t                        ob_in,
  output axi4s_dp_bus_t                        ob_out,
  input  logic                                 hwm_clr,
  output logic [CW-1:0]                        occupancy,
  output logic [CW-1:0]                        hwm,
  output logic [15:0]                          frame_beats,
  output logic [PREFIX_OB_BUF_STATS_WIDTH-1:0] stat_events
);

  logic          full;
  logic          empty;
  logic          rdy_en;
  logic          push;
  logic          pop;
  axi4s_dp_bus_t head;
  logic [CW-1:0] occ_next;
  logic [CW-1:0] hwm_next;

  prefix_ob_buf_state_e state, state_nxt;
  logic [15:0] beat_ctr, beat_ctr_nxt, ctr_inc;
  logic [15:0] frame_beats_nxt;
  logic        ovs_seen, ovs_seen_nxt;
  logic        frame_done, oversize;
  logic [PREFIX_OB_BUF_STATS_WIDTH-1:0] stat_p0;

  // rdy_en holds tready low through reset and for nothing else
  assign ib_out.tready = rdy_en & ~full;
  assign push          = ib_in.tvalid & ib_out.tready;
  assign pop           = ~empty & ob_in.tready;
  assign occ_next      = occupancy + CW'(push) - CW'(pop);

  cr_prefix_ob_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ib_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_comb begin
    ob_out = '0;
    if (!empty) begin
      ob_out        = head;
      ob_out.tvalid = 1'b1;
    end
  end

  always_comb begin
    hwm_next = hwm;
    if (hwm_clr)             hwm_next = occ_next;
    else if (occ_next > hwm) hwm_next = occ_next;
  end

  always_comb begin
    state_nxt       = state;
    beat_ctr_nxt    = beat_ctr;
    ovs_seen_nxt    = ovs_seen;
    frame_beats_nxt = frame_beats;
    frame_done      = 1'b0;
    oversize        = 1'b0;
    ctr_inc         = '0;
    if (pop) begin
      ctr_inc = (state == IDLE) ? 16'd1 : sat_inc16(beat_ctr);
      if ((ctr_inc > MAX_FRAME_BEATS) && !(state == IN_FRAME && ovs_seen)) begin
        oversize     = 1'b1;
        ovs_seen_nxt = 1'b1;
      end
      if (ob_out.tlast) begin
        frame_beats_nxt = ctr_inc;
        frame_done      = 1'b1;
        state_nxt       = IDLE;
        beat_ctr_nxt    = '0;
        ovs_seen_nxt    = 1'b0;
      end else begin
        state_nxt    = IN_FRAME;
        beat_ctr_nxt = ctr_inc;
      end
    end
  end

  always_comb begin
    stat_p0                  = '0;
    stat_p0[STAT_FRAME_DONE] = frame_done;
    stat_p0[STAT_IB_STALL]   = ib_in.tvalid & ~ib_out.tready;
    stat_p0[STAT_OB_STALL]   = ob_out.tvalid & ~ob_in.tready;
    stat_p0[STAT_OVERSIZE]   = oversize;
  end

  // p0 -> p1: register FSM, counters and stat pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en      <= 1'b0;
      state       <= IDLE;
      beat_ctr    <= '0;
      ovs_seen    <= 1'b0;
      frame_beats <= '0;
      hwm         <= '0;
      stat_events <= '0;
    end else begin
      rdy_en      <= 1'b1;
      state       <= state_nxt;
      beat_ctr    <= beat_ctr_nxt;
      ovs_seen    <= ovs_seen_nxt;
      frame_beats <= frame_beats_nxt;
      hwm         <= hwm_next;
      stat_events <= stat_p0;
    end
  end

endmodule

// File: tb/tb_cr_prefix_ob_buf.sv
// Randomized bench for cr_prefix_ob_buf against a queue-based reference model.
// Two instances share stimulus: default limits and MAX_FRAME_BEATS=4.
module tb_cr_prefix_ob_buf;
  import cr_prefix_ob_buf_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hwm_clr = 1'b0;
  axi4s_dp_bus_t ib_in = '0;
  axi4s_dp_rdy_t ob_in = '0;

  axi4s_dp_rdy_t ib_out_a, ib_out_b;
  axi4s_dp_bus_t ob_out_a, ob_out_b;
  logic [CW-1:0] occ_a, occ_b, hwm_a, hwm_b;
  logic [15:0]   fb_a, fb_b;
  logic [3:0]    ev_a, ev_b;

  always #5 clk = ~clk;

  cr_prefix_ob_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ib_in(ib_in), .ib_out(ib_out_a), .ob_in(ob_in),
    .ob_out(ob_out_a), .hwm_clr(hwm_clr), .occupancy(occ_a), .hwm(hwm_a),
    .frame_beats(fb_a), .stat_events(ev_a)
  );

  cr_prefix_ob_buf #(.DEPTH(DEPTH), .MAX_FRAME_BEATS(16'd4)) dut_small (
    .clk(clk), .rst(rst), .ib_in(ib_in), .ib_out(ib_out_b), .ob_in(ob_in),
    .ob_out(ob_out_b), .hwm_clr(hwm_clr), .occupancy(occ_b), .hwm(hwm_b),
    .frame_beats(fb_b), .stat_events(ev_b)
  );

  int errors = 0;
  int checks = 0;

  axi4s_dp_bus_t tx[$];
  axi4s_dp_bus_t mq[$];
  axi4s_dp_bus_t got[$];
  axi4s_dp_bus_t sent[$];
  int fb_seen[$];

  int m_en, m_hwm, m_run, m_fb;
  logic [3:0] m_ev_a, m_ev_b;
  int in_pct = 100, out_pct = 100;
  int pops = 0, ovs_at = -1;
  int n_done = 0, n_ibs = 0, n_obs = 0, n_ovs_a = 0, n_ovs_b = 0;

  function automatic axi4s_dp_bus_t mk_beat(input logic last);
    axi4s_dp_bus_t b;
    b.tvalid = 1'b1;
    b.tdata  = {$urandom, $urandom};
    b.tkeep  = 8'hFF;
    b.tuser  = 4'($urandom);
    b.tlast  = last;
    return b;
  endfunction

  task automatic queue_frame(input int n, input bit with_last);
    axi4s_dp_bus_t b;
    for (int i = 0; i < n; i++) begin
      b = mk_beat(with_last && (i == n - 1));
      tx.push_back(b);
      sent.push_back(b);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_hwm = 0; m_run = 0; m_fb = 0;
    m_ev_a = '0; m_ev_b = '0;
  endtask

  task automatic drive_next();
    if (tx.size() > 0 && int'($urandom_range(99)) < in_pct) ib_in = tx[0];
    else ib_in = '0;
    ob_in.tready = (int'($urandom_range(99)) < out_pct);
    hwm_clr = 1'b0;
  endtask

  // Advance one clock: reference model consumes the pre-edge inputs, then outputs are sampled 1ns after the edge.
  task automatic cycle();
    bit rdy, push, pop;
    axi4s_dp_bus_t b;
    int nr;
    logic [3:0] ea, eb;
    if (ob_out_a.tvalid && ob_in.tready) got.push_back(ob_out_a);
    if (rst) begin
      model_reset();
    end else begin
      rdy  = (m_en != 0) && (mq.size() < DEPTH);
      push = ib_in.tvalid && rdy;
      pop  = (mq.size() > 0) && ob_in.tready;
      ea = '0;
      ea[1] = ib_in.tvalid && !rdy;
      ea[2] = (mq.size() > 0) && !ob_in.tready;
      eb = ea;
      if (pop) begin
        b = mq.pop_front();
        pops++;
        nr = m_run + 1;
        if (nr > MAX_A && m_run <= MAX_A) ea[3] = 1'b1;
        if (nr > MAX_B && m_run <= MAX_B) eb[3] = 1'b1;
        if (nr > 65535) nr = 65535;
        if (b.tlast) begin
          m_fb = nr; m_run = 0; ea[0] = 1'b1; eb[0] = 1'b1;
        end else begin
          m_run = nr;
        end
      end
      if (push) begin
        mq.push_back(ib_in);
        if (tx.size() > 0) void'(tx.pop_front());
      end
      if (hwm_clr) m_hwm = mq.size();
      else if (mq.size() > m_hwm) m_hwm = mq.size();
      m_en = 1;
      m_ev_a = ea; m_ev_b = eb;
    end
    @(posedge clk); #1;
    if (ev_a[0]) begin n_done++; fb_seen.push_back(int'(fb_a)); end
    if (ev_a[1]) n_ibs++;
    if (ev_a[2]) n_obs++;
    if (ev_a[3]) n_ovs_a++;
    if (ev_b[3]) begin n_ovs_b++; ovs_at = pops; end
    drive_next();
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ib_in = mk_beat(1'b1);
    #1;
    checks++; if (ib_out_a.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b want 0", ib_out_a.tready); end
    checks++; if (ob_out_a !== '0) begin errors++; $display("FAIL reset_ob_out: got %0h want 0", ob_out_a); end
    checks++; if (occ_a !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ_a); end
    checks++; if (hwm_a !== '0) begin errors++; $display("FAIL reset_hwm: got %0d want 0", hwm_a); end
    checks++; if (fb_a !== '0) begin errors++; $display("FAIL reset_frame_beats: got %0d want 0", fb_a); end
    checks++; if (ev_a !== '0) begin errors++; $display("FAIL reset_stats: got %0h want 0", ev_a); end
    ib_in = '0;
    rst = 1'b0;
    #1;
    checks++; if (ib_out_a.tready !== 1'b0) begin errors++; $display("FAIL tready_at_deassert: got %0b want 0", ib_out_a.tready); end
    cycle();
    checks++; if (ib_out_a.tready !== 1'b1) begin errors++; $display("FAIL tready_after_reset: got %0b want 1", ib_out_a.tready); end
  endtask

  task automatic test_single_beat();
    axi4s_dp_bus_t b;
    in_pct = 100; out_pct = 100;
    b = mk_beat(1'b1);
    b.tdata = 64'hA5;
    tx.push_back(b);
    drive_next();
    cycle();
    checks++; if (ob_out_a.tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %0b want 1", ob_out_a.tvalid); end
    checks++; if (ob_out_a.tdata !== 64'hA5) begin errors++; $display("FAIL single_tdata: got %0h want a5", ob_out_a.tdata); end
    cycle();
    checks++; if (ev_a !== 4'b0001) begin errors++; $display("FAIL single_stats: got %0b want 0001", ev_a); end
    checks++; if (fb_a !== 16'd1) begin errors++; $display("FAIL single_frame_beats: got %0d want 1", fb_a); end
    checks++; if (hwm_a !== CW'(1) || hwm_b !== CW'(1)) begin errors++; $display("FAIL single_hwm: got %0d/%0d want 1", hwm_a, hwm_b); end
    checks++; if (occ_a !== '0) begin errors++; $display("FAIL single_occ: got %0d want 0", occ_a); end
  endtask

  task automatic test_backpressure();
    got.delete(); sent.delete();
    pops = 0; ovs_at = -1; n_ibs = 0; n_obs = 0; n_ovs_b = 0;
    in_pct = 100; out_pct = 0;
    queue_frame(12, 1'b1);
    drive_next();
    for (int i = 0; i < 14; i++) begin
      cycle();
      checks++; if (occ_a !== CW'(mq.size()) || occ_b !== CW'(mq.size())) begin errors++; $display("FAIL bp_occ[%0d]: got %0d want %0d", i, occ_a, mq.size()); end
      checks++; if (ib_out_a.tready !== (mq.size() < DEPTH) || ib_out_b.tready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL bp_tready[%0d]: got %0b want %0b", i, ib_out_a.tready, mq.size() < DEPTH); end
      checks++; if (ev_a !== m_ev_a) begin errors++; $display("FAIL bp_stats[%0d]: got %0b want %0b", i, ev_a, m_ev_a); end
    end
    checks++; if (occ_a !== CW'(8)) begin errors++; $display("FAIL bp_occ_full: got %0d want 8", occ_a); end
    checks++; if (hwm_a !== CW'(8)) begin errors++; $display("FAIL bp_hwm: got %0d want 8", hwm_a); end
    checks++; if (n_ibs != 6) begin errors++; $display("FAIL bp_ib_stall_count: got %0d want 6", n_ibs); end
    checks++; if (n_obs != 13) begin errors++; $display("FAIL bp_ob_stall_count: got %0d want 13", n_obs); end
  endtask

  task automatic test_stream();
    int base_done;
    base_done = n_done;
    in_pct = 100; out_pct = 100;
    drive_next();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (occ_a !== CW'(7)) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 7", i, occ_a); end
      checks++; if (ob_out_b !== mq[0]) begin errors++; $display("FAIL stream_head[%0d]: got %0h want %0h", i, ob_out_b, mq[0]); end
    end
    repeat (10) cycle();
    checks++; if (fb_a !== 16'd12) begin errors++; $display("FAIL stream_frame_beats: got %0d want 12", fb_a); end
    checks++; if (n_done - base_done != 1) begin errors++; $display("FAIL stream_frame_done: got %0d want 1", n_done - base_done); end
    checks++; if (n_ovs_b != 1 || ovs_at != 5) begin errors++; $display("FAIL stream_oversize12: got %0d at pop %0d want 1 at 5", n_ovs_b, ovs_at); end
    checks++; if (got.size() != 12) begin errors++; $display("FAIL stream_beat_count: got %0d want 12", got.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL stream_order[%0d]: got %0h want %0h", i, got[i].tdata, sent[i].tdata); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    got.delete(); sent.delete(); fb_seen.delete();
    in_pct = 60; out_pct = 60;
    queue_frame(3, 1'b1);
    queue_frame(5, 1'b1);
    drive_next();
    n = 0;
    while ((tx.size() > 0 || mq.size() > 0) && n < 400) begin
      cycle();
      n++;
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL b2b_timeout: got %0d cycles want < 400", n); end
    repeat (2) cycle();
    checks++; if (fb_seen.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", fb_seen.size()); end
    checks++; if (fb_seen.size() > 0 && fb_seen[0] != 3) begin errors++; $display("FAIL b2b_first_frame: got %0d want 3", fb_seen[0]); end
    checks++; if (fb_seen.size() > 1 && fb_seen[1] != 5) begin errors++; $display("FAIL b2b_second_frame: got %0d want 5", fb_seen[1]); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL b2b_beat_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %0h want %0h", i, got[i].tdata, sent[i].tdata); end
    end
  endtask

  task automatic test_oversize();
    int n;
    pops = 0; ovs_at = -1; n_ovs_a = 0; n_ovs_b = 0;
    in_pct = 70; out_pct = 70;
    queue_frame(6, 1'b1);
    drive_next();
    n = 0;
    while ((tx.size() > 0 || mq.size() > 0) && n < 400) begin
      cycle();
      n++;
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL ovs_timeout: got %0d cycles want < 400", n); end
    repeat (2) cycle();
    checks++; if (n_ovs_b != 1) begin errors++; $display("FAIL ovs_pulse_count: got %0d want 1", n_ovs_b); end
    checks++; if (ovs_at != 5) begin errors++; $display("FAIL ovs_pop_index: got %0d want 5", ovs_at); end
    checks++; if (fb_b !== 16'd6 || fb_a !== 16'd6) begin errors++; $display("FAIL ovs_frame_beats: got %0d/%0d want 6", fb_b, fb_a); end
    checks++; if (n_ovs_a != 0) begin errors++; $display("FAIL ovs_default_limit: got %0d want 0", n_ovs_a); end
  endtask

  task automatic test_reset_mid();
    int base_done;
    in_pct = 100; out_pct = 0;
    queue_frame(6, 1'b0);
    drive_next();
    repeat (6) cycle();
    in_pct = 0; out_pct = 100;
    drive_next();
    hwm_clr = 1'b1;
    cycle();
    checks++; if (occ_a !== CW'(5)) begin errors++; $display("FAIL mid_occ_before: got %0d want 5", occ_a); end
    checks++; if (hwm_a !== CW'(m_hwm) || m_hwm != 5) begin errors++; $display("FAIL mid_hwm_clear: got %0d want 5", hwm_a); end
    base_done = n_done;
    out_pct = 0;
    drive_next();
    rst = 1'b1;
    #1;
    checks++; if (occ_a !== '0) begin errors++; $display("FAIL mid_occ_reset: got %0d want 0", occ_a); end
    checks++; if (ob_out_a !== '0 || ib_out_a.tready !== 1'b0) begin errors++; $display("FAIL mid_outputs_reset: got %0h/%0b want 0/0", ob_out_a, ib_out_a.tready); end
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    in_pct = 100; out_pct = 0;
    queue_frame(2, 1'b1);
    drive_next();
    hwm_clr = 1'b1;
    cycle();
    checks++; if (hwm_a !== CW'(1)) begin errors++; $display("FAIL mid_hwm_clr_push: got %0d want 1", hwm_a); end
    checks++; if (n_done != base_done) begin errors++; $display("FAIL mid_stale_done: got %0d want %0d", n_done, base_done); end
    out_pct = 100;
    drive_next();
    repeat (6) cycle();
    checks++; if (fb_a !== 16'd2 || fb_b !== 16'd2) begin errors++; $display("FAIL mid_new_frame_beats: got %0d/%0d want 2", fb_a, fb_b); end
    checks++; if (n_done - base_done != 1) begin errors++; $display("FAIL mid_done_count: got %0d want 1", n_done - base_done); end
    checks++; if (occ_a !== '0 || hwm_a !== CW'(m_hwm)) begin errors++; $display("FAIL mid_final_occ_hwm: got %0d/%0d want 0/%0d", occ_a, hwm_a, m_hwm); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_stream();
    test_back_to_back();
    test_oversize();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
